// File: rtl/fly_animation_down.sv
// Fly-in animation: a 4x4 sprite descends from Y_START to Y_END above one of four slots, erasing from the background ROM between frames.
// Latency: first pixel on x/y two cycles after start is sampled high; the erase pixel follows its bg_x/bg_y address by one cycle.
// No backpressure: pixels stream one per cycle while plot=1; start low abandons the sequence on the next edge.
module fly_animation_down #(
    parameter int         X_A         = 50,
    parameter int         X_B         = 125,
    parameter int         X_C         = 200,
    parameter int         X_D         = 275,
    parameter int         Y_START     = 0,
    parameter int         Y_END       = 165,
    parameter int         HOLD_CYCLES = 190000,
    parameter logic [2:0] FLY_COLOUR  = 3'b000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic [1:0] address,
    input  logic [2:0] bg_colour,
    output logic [8:0] bg_x,
    output logic [7:0] bg_y,
    output logic [8:0] x,
    output logic [7:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       over
);

    localparam int          HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [8:0]  XA_L      = 9'(X_A);
    localparam logic [8:0]  XB_L      = 9'(X_B);
    localparam logic [8:0]  XC_L      = 9'(X_C);
    localparam logic [8:0]  XD_L      = 9'(X_D);
    localparam logic [7:0]  YS_L      = 8'(Y_START);
    localparam logic [7:0]  YE_L      = 8'(Y_END);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAW,
        S_HOLD,
        S_ERASE,
        S_UPDATE,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [8:0]      xbase_q, xbase_d;
    logic [7:0]      ybase_q, ybase_d;
    logic [8:0]      x_q, x_d;
    logic [7:0]      y_q, y_d;
    logic [2:0]      colour_q, colour_d;
    logic            plot_q, plot_d;
    logic            over_q, over_d;
    logic            erase_q, erase_d;
    logic [8:0]      pix_x;
    logic [7:0]      pix_y;

    // Current sprite pixel addressed by the 4x4 counter, row-major.
    always_comb begin
        pix_x = xbase_q + {7'd0, cnt_q[1:0]};
        pix_y = ybase_q + {6'd0, cnt_q[3:2]};
    end

    // Background ROM address is only driven while erasing; zero otherwise.
    always_comb begin
        bg_x = 9'd0;
        bg_y = 8'd0;
        if (state_q == S_ERASE) begin
            bg_x = pix_x;
            bg_y = pix_y;
        end
    end

    // Next-state, counters and next values of the registered VGA outputs.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        xbase_d  = xbase_q;
        ybase_d  = ybase_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        over_d   = 1'b0;
        erase_d  = 1'b0;
        if (!start) begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
            hold_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_LOAD;
                    cnt_d   = 4'd0;
                    hold_d  = '0;
                end
                S_LOAD: begin
                    case (address)
                        2'b00:   xbase_d = XA_L;
                        2'b01:   xbase_d = XB_L;
                        2'b10:   xbase_d = XC_L;
                        default: xbase_d = XD_L;
                    endcase
                    ybase_d = YS_L;
                    cnt_d   = 4'd0;
                    state_d = S_DRAW;
                end
                S_DRAW: begin
                    x_d      = pix_x;
                    y_d      = pix_y;
                    colour_d = FLY_COLOUR;
                    plot_d   = 1'b1;
                    cnt_d    = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        hold_d  = '0;
                        state_d = (ybase_q == YE_L) ? S_DONE : S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d  = '0;
                        cnt_d   = 4'd0;
                        state_d = S_ERASE;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                S_ERASE: begin
                    // Colour arrives from the ROM in the cycle these coordinates are shown.
                    x_d     = pix_x;
                    y_d     = pix_y;
                    plot_d  = 1'b1;
                    erase_d = 1'b1;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_d = S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    ybase_d = ybase_q + 8'd1;
                    cnt_d   = 4'd0;
                    state_d = S_DRAW;
                end
                S_DONE: begin
                    over_d = 1'b1;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // All state, counters and VGA output registers; asynchronous clear.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            hold_q   <= '0;
            xbase_q  <= 9'd0;
            ybase_q  <= 8'd0;
            x_q      <= 9'd0;
            y_q      <= 8'd0;
            colour_q <= 3'd0;
            plot_q   <= 1'b0;
            over_q   <= 1'b0;
            erase_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hold_q   <= hold_d;
            xbase_q  <= xbase_d;
            ybase_q  <= ybase_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            over_q   <= over_d;
            erase_q  <= erase_d;
        end
    end

    // Erase pixels take their colour straight from the ROM data for the registered address.
    always_comb begin
        x      = x_q;
        y      = y_q;
        colour = erase_q ? bg_colour : colour_q;
        plot   = plot_q;
        over   = over_q;
    end

endmodule

// File: tb/tb_fly_animation_down.sv
// Bench for fly_animation_down: random slots, random abort points and mid-erase reset against a frame-timeline model.
// Latency: model predicts outputs per edge count since start was first sampled.
// Backpressure: none; the bench streams one cycle at a time.
module tb_fly_animation_down;

    localparam int H  = 4;
    localparam int YE = 3;
    localparam int N  = YE + 1;            // frames drawn (Y_START = 0)
    localparam int P  = 16 + H + 16 + 1;   // non-final frame period

    logic       clock = 1'b0;
    logic       resetn;
    logic       start;
    logic [1:0] address;
    logic [2:0] bg_colour = 3'd0;
    logic [8:0] bg_x;
    logic [7:0] bg_y;
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       over;

    int tests = 0;
    int fails = 0;
    int plot_count = 0;

    fly_animation_down #(
        .HOLD_CYCLES(H),
        .Y_END(YE)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .start(start),
        .address(address),
        .bg_colour(bg_colour),
        .bg_x(bg_x),
        .bg_y(bg_y),
        .x(x),
        .y(y),
        .colour(colour),
        .plot(plot),
        .over(over)
    );

    always #5 clock = ~clock;

    // Background ROM model with one cycle of read latency.
    always @(posedge clock) bg_colour <= bg_x[2:0] ^ bg_y[2:0];

    function automatic logic [8:0] slot_x(input logic [1:0] a);
        case (a)
            2'b00:   return 9'd50;
            2'b01:   return 9'd125;
            2'b10:   return 9'd200;
            default: return 9'd275;
        endcase
    endfunction

    task automatic chk1(input string tag, input logic got, input logic exp, input int k);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s k=%0d got %b expected %b", tag, k, got, exp);
        end
    endtask

    task automatic chkv(input string tag, input int got, input int exp, input int k);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s k=%0d got %0d expected %0d", tag, k, got, exp);
        end
    endtask

    // Expected outputs k edges after the edge at which start was first sampled high.
    task automatic check_cycle(input int k, input logic [8:0] xb);
        int r, f, o, i;
        logic ep, eo;
        int ex, ey, ec;
        bit erase;
        ep = 1'b0; eo = 1'b0; ex = 0; ey = 0; ec = 0; erase = 0; i = 0;
        r = k - 2;
        if (r >= 0) begin
            f = r / P;
            o = r % P;
            eo = (r >= (N - 1) * P + 16);
            if (f < N && o < 16) begin
                ep = 1'b1; i = o;
            end else if (f < N - 1 && o >= 16 + H && o < 32 + H) begin
                ep = 1'b1; i = o - 16 - H; erase = 1;
            end
            if (ep) begin
                ex = int'(xb) + i % 4;
                ey = f + i / 4;
                ec = erase ? ((ex % 8) ^ (ey % 8)) : 0;
            end
        end
        chk1("plot", plot, ep, k);
        chk1("over", over, eo, k);
        if (ep) begin
            chkv("x", int'(x), ex, k);
            chkv("y", int'(y), ey, k);
            chkv("colour", int'(colour), ec, k);
        end
        if (plot === 1'b1) plot_count++;
    endtask

    // Runs edges 0..kmax after start is sampled, checking each; optionally scrambles address after LOAD.
    task automatic run(input logic [8:0] xb, input int kmax, input bit scramble);
        for (int k = 0; k <= kmax; k++) begin
            @(posedge clock);
            #1;
            check_cycle(k, xb);
            if (scramble && k >= 2) address = 2'($urandom);
        end
    endtask

    task automatic check_idle(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clock);
            #1;
            chk1("idle_plot", plot, 1'b0, c);
            chk1("idle_over", over, 1'b0, c);
        end
    endtask

    logic [1:0] a;
    int kstop;

    initial begin
        // Reset held with start high: everything zero.
        resetn = 1'b0; start = 1'b1; address = 2'b10;
        repeat (3) @(posedge clock);
        #1;
        chkv("rst_x", int'(x), 0, 0);
        chkv("rst_y", int'(y), 0, 0);
        chkv("rst_colour", int'(colour), 0, 0);
        chk1("rst_plot", plot, 1'b0, 0);
        chk1("rst_over", over, 1'b0, 0);

        // Release reset: draw sweep + first erase + second draw on slot 10, address scrambled after LOAD.
        @(negedge clock); resetn = 1'b1;
        run(9'd200, 2 + P + 16, 1'b1);

        // Drop start mid-HOLD, then restart on slot 01.
        start = 1'b0; address = 2'b01;
        check_idle(3);
        @(negedge clock); start = 1'b1;
        run(9'd125, 2 + 16 + 2, 1'b0);

        // Drop mid-HOLD of that run.
        start = 1'b0;
        check_idle(3);

        // Full run on slot 00: 112 plots, then over with plot low, then over falls after start drops.
        @(negedge clock); start = 1'b1; address = 2'b00; plot_count = 0;
        run(9'd50, 2 + (N - 1) * P + 16 + 10, 1'b1);
        chkv("total_plots", plot_count, 112, 0);
        start = 1'b0;
        @(posedge clock); #1;
        chk1("over_fall", over, 1'b0, 0);
        check_idle(2);

        // Random slots with random abort points.
        for (int t = 0; t < 6; t++) begin
            a = 2'($urandom);
            kstop = int'($urandom_range(0, 2 + (N - 1) * P + 20));
            @(negedge clock); start = 1'b1; address = a;
            run(slot_x(a), kstop, 1'b1);
            start = 1'b0;
            check_idle(3);
        end

        // Asynchronous reset mid-ERASE clears outputs at once; sequence restarts at Y_START.
        @(negedge clock); start = 1'b1; address = 2'b10;
        run(9'd200, 2 + 16 + H + 6, 1'b1);
        chk1("pre_rst_plot", plot, 1'b1, 0);
        #2 resetn = 1'b0;
        #1;
        chk1("arst_plot", plot, 1'b0, 0);
        chkv("arst_x", int'(x), 0, 0);
        chkv("arst_y", int'(y), 0, 0);
        chkv("arst_colour", int'(colour), 0, 0);
        chk1("arst_over", over, 1'b0, 0);
        @(negedge clock); address = 2'b11; resetn = 1'b1;
        run(9'd275, 2 + P + 4, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
